// File: rtl/frame_sync_ctrl_pkg.sv
// Shared state encoding, default framing constants and small helpers
// used by the frame-synchronisation controller and its sync matcher.
package frame_sync_ctrl_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'b00,
      VERIFY = 2'b01,
      LOCKED = 2'b10
   } sync_state_e;

   localparam int         DEF_PAT_W      = 4;
   localparam logic [3:0] DEF_SYNC_PAT   = 4'b1010;
   localparam int         DEF_FRAME_LEN  = 12;
   localparam int         DEF_LOCK_CNT   = 2;
   localparam int         DEF_UNLOCK_CNT = 2;
   localparam int         ERR_W          = 8;

   // The error counter sticks at all-ones instead of wrapping back to zero.
   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
      return (value == {ERR_W{1'b1}}) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/frame_sync_ctrl_matcher.sv
// Sliding-window sync word detector: keeps the last PAT_W-1 bits and flags
// a match in the same cycle the final sync bit arrives on din.
module sync_pattern_matcher
   import frame_sync_ctrl_pkg::*;
#(
   parameter int               PAT_W    = DEF_PAT_W,
   parameter logic [PAT_W-1:0] SYNC_PAT = PAT_W'(DEF_SYNC_PAT)
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic din,
   output logic match
);

   logic [PAT_W-2:0] sr;
   logic [PAT_W-1:0] window;

   assign window = {sr, din};
   assign match  = en && (window == SYNC_PAT);

   // Never cleared on a hit, so overlapping sync words are still seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= '0;
      end else if (en) begin
         sr <= window[PAT_W-2:0];
      end
   end

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frame-sync controller: hunts for the sync word, confirms it at frame spacing,
// then delivers payload bits with frame markers and flywheels over sync misses.
module frame_sync_ctrl
   import frame_sync_ctrl_pkg::*;
#(
   parameter int               PAT_W      = DEF_PAT_W,
   parameter logic [PAT_W-1:0] SYNC_PAT   = PAT_W'(DEF_SYNC_PAT),
   parameter int               FRAME_LEN  = DEF_FRAME_LEN,
   parameter int               LOCK_CNT   = DEF_LOCK_CNT,
   parameter int               UNLOCK_CNT = DEF_UNLOCK_CNT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         din,
   output logic                         locked,
   output logic                         frame_start,
   output logic                         dout_valid,
   output logic                         dout,
   output logic [$clog2(FRAME_LEN)-1:0] bit_idx,
   output logic [ERR_W-1:0]             err_cnt
);

   localparam int PW = $clog2(FRAME_LEN);
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int MW = $clog2(UNLOCK_CNT + 1);

   localparam logic [PW-1:0] LAST_POS   = PW'(FRAME_LEN - 1);
   localparam logic [PW-1:0] PAY_LEN    = PW'(FRAME_LEN - PAT_W);
   localparam logic [GW-1:0] LOCK_TGT   = GW'(LOCK_CNT);
   localparam logic [MW-1:0] UNLOCK_TGT = MW'(UNLOCK_CNT);

   sync_state_e      state, state_n;
   logic [PW-1:0]    pos, pos_n, pos_wrap;
   logic [GW-1:0]    good_cnt, good_n;
   logic [MW-1:0]    miss_cnt, miss_n;
   logic [ERR_W-1:0] err_n;
   logic             match, boundary, payload_ok, start_n;

   sync_pattern_matcher #(
      .PAT_W    (PAT_W),
      .SYNC_PAT (SYNC_PAT)
   ) u_matcher (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .din   (din),
      .match (match)
   );

   assign boundary   = en && (pos == LAST_POS);
   assign pos_wrap   = (pos == LAST_POS) ? '0 : pos + PW'(1);
   assign payload_ok = en && (state == LOCKED) && (pos < PAY_LEN);

   // Next-state and counter updates; with en low everything holds.
   always_comb begin
      state_n = state;
      pos_n   = pos;
      good_n  = good_cnt;
      miss_n  = miss_cnt;
      err_n   = err_cnt;
      start_n = 1'b0;
      if (en) begin
         unique case (state)
            HUNT: begin
               if (match) begin
                  pos_n   = '0;
                  good_n  = GW'(1);
                  miss_n  = '0;
                  state_n = (LOCK_CNT == 1) ? LOCKED : VERIFY;
               end
            end
            VERIFY: begin
               pos_n = pos_wrap;
               if (boundary) begin
                  if (!match) begin
                     state_n = HUNT;
                  end else if (good_cnt + GW'(1) == LOCK_TGT) begin
                     state_n = LOCKED;
                     miss_n  = '0;
                     start_n = 1'b1;
                  end else begin
                     good_n = good_cnt + GW'(1);
                  end
               end
            end
            LOCKED: begin
               pos_n = pos_wrap;
               if (boundary) begin
                  if (match) begin
                     miss_n  = '0;
                     start_n = 1'b1;
                  end else begin
                     err_n  = sat_inc(err_cnt);
                     miss_n = miss_cnt + MW'(1);
                     if (miss_cnt + MW'(1) == UNLOCK_TGT) begin
                        state_n = HUNT;
                        good_n  = '0;
                     end else begin
                        start_n = 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_n = HUNT;
            end
         endcase
      end
   end

   // Reset wins over any same-cycle boundary; outputs register alongside state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= HUNT;
         pos         <= '0;
         good_cnt    <= '0;
         miss_cnt    <= '0;
         err_cnt     <= '0;
         locked      <= 1'b0;
         frame_start <= 1'b0;
         dout_valid  <= 1'b0;
         dout        <= 1'b0;
         bit_idx     <= '0;
      end else begin
         state       <= state_n;
         pos         <= pos_n;
         good_cnt    <= good_n;
         miss_cnt    <= miss_n;
         err_cnt     <= err_n;
         locked      <= (state_n == LOCKED);
         frame_start <= start_n;
         dout_valid  <= payload_ok;
         dout        <= payload_ok & din;
         bit_idx     <= payload_ok ? pos : '0;
      end
   end

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Self-checking bench for frame_sync_ctrl: a behavioural model queues the expected
// outputs for every driven bit and each is compared after the following clock edge.
module tb_frame_sync_ctrl;

   localparam int FRAME_LEN = 12;
   localparam int PAT_W     = 4;
   localparam int PAY_LEN   = FRAME_LEN - PAT_W;
   localparam int LOCK      = 2;
   localparam int UNLOCK    = 2;
   localparam int SYNC      = 4'b1010;
   localparam int IW        = $clog2(FRAME_LEN);
   localparam int M_HUNT    = 0;
   localparam int M_VERIFY  = 1;
   localparam int M_LOCKED  = 2;

   logic          clk = 1'b0;
   logic          rst, en, din;
   logic          locked, frame_start, dout_valid, dout;
   logic [IW-1:0] bit_idx;
   logic [7:0]    err_cnt;

   frame_sync_ctrl #(
      .PAT_W      (PAT_W),
      .SYNC_PAT   (4'b1010),
      .FRAME_LEN  (FRAME_LEN),
      .LOCK_CNT   (LOCK),
      .UNLOCK_CNT (UNLOCK)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .din         (din),
      .locked      (locked),
      .frame_start (frame_start),
      .dout_valid  (dout_valid),
      .dout        (dout),
      .bit_idx     (bit_idx),
      .err_cnt     (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic locked;
      logic frame_start;
      logic dout_valid;
      logic dout;
      int   bit_idx;
      int   err_cnt;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         m_state, m_sr, m_pos, m_good, m_miss, m_err;
   int         cap_cnt = 0;
   logic [7:0] cap_bits = '0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, got, want);
      end
   endtask

   // Reference behaviour, advanced once per driven bit before the clock edge.
   task automatic modelStep(input bit r, input bit e, input bit d, output exp_t x);
      int win;
      bit hit, bnd;
      x.locked = 0; x.frame_start = 0; x.dout_valid = 0; x.dout = 0; x.bit_idx = 0; x.err_cnt = 0;
      if (r) begin
         m_state = M_HUNT; m_sr = 0; m_pos = 0; m_good = 0; m_miss = 0; m_err = 0;
      end else if (e) begin
         win = ((m_sr << 1) | int'(d)) & 15;
         hit = (win == SYNC);
         bnd = (m_pos == FRAME_LEN - 1);
         if (m_state == M_LOCKED && m_pos < PAY_LEN) begin
            x.dout_valid = 1; x.dout = d; x.bit_idx = m_pos;
         end
         case (m_state)
            M_HUNT: if (hit) begin
               m_pos = 0; m_good = 1; m_state = M_VERIFY;
            end
            M_VERIFY: begin
               if (bnd) begin
                  if (!hit) m_state = M_HUNT;
                  else if (m_good + 1 == LOCK) begin
                     m_state = M_LOCKED; m_miss = 0; x.frame_start = 1;
                  end else m_good++;
               end
               m_pos = (m_pos + 1) % FRAME_LEN;
            end
            default: begin
               if (bnd) begin
                  if (hit) begin
                     m_miss = 0; x.frame_start = 1;
                  end else begin
                     if (m_err < 255) m_err++;
                     m_miss++;
                     if (m_miss == UNLOCK) begin
                        m_state = M_HUNT; m_good = 0;
                     end else x.frame_start = 1;
                  end
               end
               m_pos = (m_pos + 1) % FRAME_LEN;
            end
         endcase
         m_sr = win & 7;
      end
      x.locked  = (m_state == M_LOCKED);
      x.err_cnt = m_err;
   endtask

   task automatic applyStimulus(input bit r, input bit e, input bit d);
      exp_t x, want;
      modelStep(r, e, d, x);
      exp_q.push_back(x);
      rst = r; en = e; din = d;
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      checkOutput("locked", 32'(locked), 32'(want.locked));
      checkOutput("frame_start", 32'(frame_start), 32'(want.frame_start));
      checkOutput("dout_valid", 32'(dout_valid), 32'(want.dout_valid));
      checkOutput("err_cnt", 32'(err_cnt), 32'(want.err_cnt));
      if (want.dout_valid) begin
         checkOutput("dout", 32'(dout), 32'(want.dout));
         checkOutput("bit_idx", 32'(bit_idx), 32'(want.bit_idx));
      end
      if (dout_valid) begin
         cap_bits = {cap_bits[6:0], dout};
         cap_cnt++;
      end
   endtask

   task automatic sendBits(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) applyStimulus(1'b0, 1'b1, bits[i]);
   endtask

   task automatic sendFrame(input logic [7:0] payload, input logic [3:0] sync);
      sendBits(16'(payload), 8);
      sendBits(16'(sync), 4);
   endtask

   task automatic resetDut();
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
   endtask

   // Bring the stream from a clean hunt to lock; a trailing run of ones cannot end a sync word.
   task automatic acquire(input logic [7:0] payload);
      sendBits(16'hF, 4);
      sendBits(16'(SYNC), 4);
      sendFrame(payload, 4'b1010);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int  hist;
      bit  b;
      rst = 1'b1; en = 1'b0; din = 1'b0;

      $display("[TB] reset and sync-free random traffic");
      resetDut();
      checkOutput("rst_locked", 32'(locked), 32'd0);
      checkOutput("rst_dout_valid", 32'(dout_valid), 32'd0);
      checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
      hist = 0;
      repeat (30) begin
         b = 1'($urandom_range(0, 1));
         if (hist == 3'b101) b = 1'b1;
         applyStimulus(1'b0, 1'b1, b);
         hist = ((hist << 1) | int'(b)) & 7;
      end
      checkOutput("random_no_lock", 32'(locked), 32'd0);

      $display("[TB] acquisition and first locked frame");
      sendBits(16'hF, 4);
      sendBits(16'(SYNC), 4);
      sendBits(16'hC5, 8);
      sendBits(16'b101, 3);
      checkOutput("acq_not_yet", 32'(locked), 32'd0);
      sendBits(16'b0, 1);
      checkOutput("acq_locked", 32'(locked), 32'd1);
      checkOutput("acq_frame_start", 32'(frame_start), 32'd1);
      cap_cnt = 0;
      sendBits(16'h3C, 8);
      checkOutput("payload1_bits", 32'(cap_bits), 32'h3C);
      checkOutput("payload1_count", 32'(cap_cnt), 32'd8);
      sendBits(16'(SYNC), 4);
      checkOutput("locked_sync_start", 32'(frame_start), 32'd1);

      $display("[TB] corrupted second sync during verify");
      resetDut();
      sendBits(16'hF, 4);
      sendBits(16'(SYNC), 4);
      sendFrame(8'hC5, 4'b1011);
      checkOutput("verify_fail", 32'(locked), 32'd0);
      sendBits(16'(SYNC), 4);
      sendFrame(8'h96, 4'b1010);
      checkOutput("rehunt_locked", 32'(locked), 32'd1);

      $display("[TB] sync misses while locked");
      cap_cnt = 0;
      sendFrame(8'h5A, 4'b1110);
      checkOutput("miss1_locked", 32'(locked), 32'd1);
      checkOutput("miss1_err", 32'(err_cnt), 32'd1);
      checkOutput("miss1_payload", 32'(cap_bits), 32'h5A);
      sendFrame(8'hE1, 4'b0110);
      checkOutput("miss2_unlock", 32'(locked), 32'd0);
      checkOutput("miss2_err", 32'(err_cnt), 32'd2);

      $display("[TB] gapped enable while locked");
      acquire(8'hC5);
      checkOutput("gap_relock", 32'(locked), 32'd1);
      cap_cnt = 0;
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] pay;
         pay = 8'hA7;
         applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)));
         applyStimulus(1'b0, 1'b1, pay[i]);
      end
      checkOutput("gap_payload", 32'(cap_bits), 32'hA7);
      checkOutput("gap_count", 32'(cap_cnt), 32'd8);
      for (int i = 3; i >= 0; i--) begin
         logic [3:0] s;
         s = 4'b1010;
         applyStimulus(1'b0, 1'b0, 1'b1);
         applyStimulus(1'b0, 1'b1, s[i]);
      end
      checkOutput("gap_no_slip", 32'(frame_start), 32'd1);
      cap_cnt = 0;
      sendFrame(8'h4B, 4'b1010);
      checkOutput("post_gap_payload", 32'(cap_bits), 32'h4B);

      $display("[TB] reset in the middle of a locked frame");
      sendBits(16'hF, 4);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("midrst_locked", 32'(locked), 32'd0);
      checkOutput("midrst_valid", 32'(dout_valid), 32'd0);
      checkOutput("midrst_err", 32'(err_cnt), 32'd0);
      sendBits(16'(SYNC), 4);
      sendBits(16'h33, 8);
      sendBits(16'b101, 3);
      checkOutput("reacq_one_sync", 32'(locked), 32'd0);
      sendBits(16'b0, 1);
      checkOutput("reacq_locked", 32'(locked), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
